// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file, one synchronous write port and
// two combinational read ports (MIPS integer register file).
// Optional build macro: REGFILE_WRBYPASS_EN -- when defined, a read of the
// address being written in the same cycle returns wdata (write-through);
// when undefined, reads always return stored contents.
// Register 0 reads as zero and ignores writes when ZERO_REG is 1.

module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 32'sd0);

    // Current contents of every register as seen by the read muxes.
    logic [WIDTH-1:0] mem_s [DEPTH];
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    // Select the value a read port returns: bypassed write data when the
    // write-through option is built in and the addresses match, otherwise
    // the stored value. Register 0 never bypasses when it is hardwired.
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [ADDR_W-1:0] ra,
        input logic [WIDTH-1:0]  stored,
        input logic              wr_en,
        input logic              rst,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd
    );
        logic [WIDTH-1:0] result;
        logic             is_zero_reg;
        is_zero_reg = ZERO_EN && (ra == {ADDR_W{1'b0}});
`ifdef REGFILE_WRBYPASS_EN
        if (is_zero_reg) begin
            result = {WIDTH{1'b0}};
        end else if (wr_en && !rst && (ra == wa)) begin
            result = wd;
        end else begin
            result = stored;
        end
`else
        if (is_zero_reg) begin
            result = {WIDTH{1'b0}};
        end else begin
            result = stored;
        end
        // Write-port inputs only matter for the bypass build.
        if (wr_en && !rst && (wa == ra) && (wd == stored)) begin
            result = result;
        end else begin
            result = result;
        end
`endif
        return result;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_EN && (gi == 0)) begin : g_zero
                // Hardwired zero register: no storage needed.
                assign mem_s[gi] = {WIDTH{1'b0}};
            end else begin : g_store
                logic             wr_sel_s;
                logic [WIDTH-1:0] reg_r;

                // Per-register write enable; an X on we leaves unselected
                // registers alone because the address compare is 0 there.
                assign wr_sel_s = (waddr == ADDR_W'(gi)) && we;

                // Register storage: synchronous clear wins over a write.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        reg_r <= {WIDTH{1'b0}};
                    end else if (wr_sel_s) begin
                        reg_r <= wdata;
                    end else begin
                        reg_r <= reg_r;
                    end
                end

                assign mem_s[gi] = reg_r;
            end
        end
    endgenerate

    // Read port 1: combinational lookup, zero-cycle latency.
    always_comb begin
        rd1_s = {WIDTH{1'b0}};
        rd1_s = read_sel(raddr1, mem_s[raddr1], we, reset, waddr, wdata);
    end

    // Read port 2: identical, independent lookup.
    always_comb begin
        rd2_s = {WIDTH{1'b0}};
        rd2_s = read_sel(raddr2, mem_s[raddr2], we, reset, waddr, wdata);
    end

    assign rdata1 = rd1_s;
    assign rdata2 = rd2_s;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w. Expectations follow the
// REGFILE_WRBYPASS_EN build option. A second instance with ZERO_REG=0
// covers register 0 as ordinary storage.

module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] nz_rdata1;
    logic [31:0] nz_rdata2;

    int checks;
    int errors;

    regfile_2r1w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
    );

    regfile_2r1w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(nz_rdata1), .raddr2(raddr2), .rdata2(nz_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write on the next rising edge, then we drops again.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset;
        do_write(5'd7, 32'hDEADBEEF);
        raddr1 = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_prewrite: got %h expected %h", rdata1, 32'hDEADBEEF);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h00000000) begin
            errors++;
            $display("FAIL reset_reg7: got %h expected %h", rdata1, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_all[%0d]: got %h/%h expected 0/0", i, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_basic_write;
        do_write(5'd5, 32'h12345678);
        raddr2 = 5'd5;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (rdata2 !== 32'h12345678) begin
                errors++;
                $display("FAIL basic_hold[%0d]: got %h expected %h", c, rdata2, 32'h12345678);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        raddr1 = 5'd0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_before: got %h expected %h", rdata1, 32'h0);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_after: got %h expected %h", rdata1, 32'h0);
        end
    endtask

    task automatic test_reset_vs_write;
        do_write(5'd3, 32'h00000033);
        do_write(5'd4, 32'h00000044);
        @(negedge clk);
        reset = 1'b1;
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        raddr1 = 5'd3; raddr2 = 5'd4;
        #1;
        // Reset has no effect until the edge; bypass is off while reset is high.
        checks++;
        if (rdata1 !== 32'h00000033 || rdata2 !== 32'h00000044) begin
            errors++;
            $display("FAIL reset_no_async: got %h/%h expected %h/%h",
                     rdata1, rdata2, 32'h33, 32'h44);
        end
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_beats_write: got %h/%h expected 0/0", rdata1, rdata2);
        end
    endtask

    task automatic test_read_during_write;
        logic [31:0] exp_pre;
`ifdef REGFILE_WRBYPASS_EN
        exp_pre = 32'h22222222;
`else
        exp_pre = 32'h11111111;
`endif
        do_write(5'd9, 32'h11111111);
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h22222222;
        raddr1 = 5'd9;
        #1;
        checks++;
        if (rdata1 !== exp_pre) begin
            errors++;
            $display("FAIL rdw_before: got %h expected %h", rdata1, exp_pre);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h22222222) begin
            errors++;
            $display("FAIL rdw_after: got %h expected %h", rdata1, 32'h22222222);
        end
    endtask

    task automatic test_dual_port;
        logic [31:0] e1;
        logic [31:0] e2;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'h100 + 32'(i));
        end
        // Idle cycle with garbage on the write bus.
        @(negedge clk);
        we = 1'b0; waddr = 5'($urandom); wdata = $urandom;
        // Unknown write enable aimed at register 10 only.
        @(negedge clk);
        we = 1'bx; waddr = 5'd10; wdata = 32'h0BAD0BAD;
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            e1 = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            e2 = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
            #1;
            if (i != 10) begin
                checks++;
                if (rdata1 !== e1) begin
                    errors++;
                    $display("FAIL dual_p1[%0d]: got %h expected %h", i, rdata1, e1);
                end
            end
            if ((31 - i) != 10) begin
                checks++;
                if (rdata2 !== e2) begin
                    errors++;
                    $display("FAIL dual_p2[%0d]: got %h expected %h", 31 - i, rdata2, e2);
                end
            end
        end
        raddr1 = 5'd17; raddr2 = 5'd17;
        #1;
        checks++;
        if (rdata1 !== 32'h111 || rdata2 !== 32'h111) begin
            errors++;
            $display("FAIL dual_same: got %h/%h expected %h", rdata1, rdata2, 32'h111);
        end
    endtask

    task automatic test_reg0_storage;
        do_write(5'd0, 32'h0BADF00D);
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        checks++;
        if (nz_rdata1 !== 32'h0BADF00D || nz_rdata2 !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL reg0_plain: got %h/%h expected %h", nz_rdata1, nz_rdata2, 32'h0BADF00D);
        end
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_hardwired: got %h expected %h", rdata1, 32'h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_reset_vs_write();
        test_read_during_write();
        test_dual_port();
        test_reg0_storage();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
